// File: rtl/addsub_pkg.sv
// Shared types and constants for the two-requester add/subtract arbiter.
// Holds the default datapath width, the requester id type and the FSM state type.
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  // Encodings are kept as plain constants too, so older code that compares
  // raw state bits keeps working.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef enum logic [0:0] {
    EMPTY = ST_EMPTY,
    FULL  = ST_FULL
  } state_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple-carry adder/subtracter: sum = a + (b ^ {s}) + s.
// Reports carry out of the MSB and signed overflow (carry into MSB xor carry out).
module addsub_core
  import addsub_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             s,
  output logic [width-1:0] sum,
  output logic             cout,
  output logic             v
);

  logic [width-1:0] bx;
  logic [width:0]   c;

  assign bx   = b ^ {width{s}};
  assign c[0] = s;

  for (genvar i = 0; i < width; i++) begin : g_bit
    assign sum[i]  = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout = c[width];
  assign v    = c[width] ^ c[width-1];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/subtract core between two requesters.
// One operation is accepted per cycle into a single registered response slot.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_a,
  input  logic [width-1:0] req0_b,
  input  logic             req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_a,
  input  logic [width-1:0] req1_b,
  input  logic             req1_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [width-1:0] rsp_sum,
  output logic             rsp_v,
  output logic             rsp_cout
);

  state_e  state;
  req_id_e ptr;

  logic    free;
  logic    grant0;
  logic    grant1;
  logic    accept0;
  logic    accept1;
  logic    accept;
  req_id_e sel;

  logic [width-1:0] op_a;
  logic [width-1:0] op_b;
  logic             op_s;
  logic [width-1:0] core_sum;
  logic             core_cout;
  logic             core_v;

  assign rsp_valid = (state == FULL);

  // The slot can take a new result if empty or if the current one retires now.
  assign free = !rsp_valid || rsp_ready;

  assign grant0 = req0_valid && (!req1_valid || ptr == REQ0);
  assign grant1 = req1_valid && (!req0_valid || ptr == REQ1);

  assign req0_ready = grant0 && free && !rst;
  assign req1_ready = grant1 && free && !rst;

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;
  assign accept  = accept0 || accept1;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a variable unassigned and infers a latch.
  always_comb begin
    sel  = REQ0;
    op_a = req0_a;
    op_b = req0_b;
    op_s = req0_s;
    if (grant1) begin
      sel  = REQ1;
      op_a = req1_a;
      op_b = req1_b;
      op_s = req1_s;
    end
  end

  addsub_core #(
    .width (width)
  ) u_core (
    .a    (op_a),
    .b    (op_b),
    .s    (op_s),
    .sum  (core_sum),
    .cout (core_cout),
    .v    (core_v)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= REQ0;
      rsp_id   <= 1'b0;
      rsp_sum  <= '0;
      rsp_v    <= 1'b0;
      rsp_cout <= 1'b0;
    end else if (accept) begin
      state    <= FULL;
      ptr      <= other_req(sel);
      rsp_id   <= sel;
      rsp_sum  <= core_sum;
      rsp_v    <= core_v;
      rsp_cout <= core_cout;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule
